i2c_target_responder: RTL and testbench

//  Clocked I2C target (responder) model for the VT I2C environment: answers tester-driven
//  I2C_SCL/I2C_SDA transactions with a small register file. Drives I2C_SDA_oe (1 = pull SDA
//  low, open-drain), the enable the contention monitor consumes. Gives the tester patterns a

---
 rtl/i2c_vt_pkg.sv | 32 +++
 rtl/i2c_pin_sync.sv | 58 +++++
 rtl/i2c_target_responder.sv | 189 ++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_vt_pkg.sv
// Shared types for the VT I2C blocks: responder FSM states, ACK/NACK levels and
// the bus-condition encoding produced by the pin synchronizer.
package i2c_vt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'd0,
    EVT_START = 2'd1,
    EVT_STOP  = 2'd2
  } bus_evt_e;

  // Address byte is {addr[6:0], rw}.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
    return addr_byte[7:1] == dev;
  endfunction

endpackage

// File: rtl/i2c_pin_sync.sv
// SCL/SDA metastability synchronizer with SCL edge and START/STOP detection.
// START/STOP need SCL high on both the current and previous synchronized sample.
module i2c_pin_sync
  import i2c_vt_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     scl,
  input  logic     sda,
  output logic     sda_s,
  output logic     scl_rise,
  output logic     scl_fall,
  output bus_evt_e evt
);

  logic [SYNC_STAGES-1:0] scl_p0;
  logic [SYNC_STAGES-1:0] sda_p0;
  logic                   scl_p1;
  logic                   sda_p1;
  logic                   scl_s;
  logic                   start_det;
  logic                   stop_det;

  // Reset to the idle-bus level so leaving reset never fabricates a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0 <= '1;
      sda_p0 <= '1;
      scl_p1 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= {scl_p0[SYNC_STAGES-2:0], scl};
      sda_p0 <= {sda_p0[SYNC_STAGES-2:0], sda};
      scl_p1 <= scl_p0[SYNC_STAGES-1];
      sda_p1 <= sda_p0[SYNC_STAGES-1];
    end
  end

  // Edge-detect stage
  assign scl_s     = scl_p0[SYNC_STAGES-1];
  assign sda_s     = sda_p0[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p1;
  assign scl_fall  = ~scl_s & scl_p1;
  assign start_det = ~sda_s & sda_p1 & scl_s & scl_p1;
  assign stop_det  = sda_s & ~sda_p1 & scl_s & scl_p1;

  always_comb begin
    evt = EVT_NONE;
    if (stop_det) begin
      evt = EVT_STOP;
    end else if (start_det) begin
      evt = EVT_START;
    end
  end

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target with a small register file: pointer byte then writes, or reads from
// the pointer after a (repeated) START. SDA is driven open-drain via I2C_SDA_oe.
module i2c_target_responder
  import i2c_vt_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         REG_DEPTH   = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        AW          = $clog2(REG_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          I2C_SCL,
  input  logic          I2C_SDA,
  output logic          I2C_SDA_oe,
  input  logic          host_wr_en,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          busy,
  output logic          stop_evt,
  output logic          nack_evt
);

  logic          sda_s;
  logic          scl_rise;
  logic          scl_fall;
  bus_evt_e      evt;

  state_e        state;
  logic [3:0]    bit_cnt;
  logic [AW-1:0] ptr;
  logic          rw;
  logic [6:0]    rx_sr;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_byte;
  logic [7:0]    regs [REG_DEPTH];

  logic          i2c_we;
  logic          load_tx;
  logic [AW-1:0] tx_idx;

  i2c_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (I2C_SCL),
    .sda      (I2C_SDA),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .evt      (evt)
  );

  assign rx_byte    = {rx_sr, sda_s};
  assign host_rdata = regs[host_addr];

  // Decode of the bit-sampling edge
  always_comb begin
    i2c_we  = 1'b0;
    load_tx = 1'b0;
    tx_idx  = ptr;
    if (evt == EVT_NONE && scl_rise) begin
      if (state == ST_WDATA && bit_cnt == 4'd7) begin
        i2c_we = 1'b1;
      end
      if (state == ST_ADDR_ACK && rw) begin
        load_tx = 1'b1;
      end else if (state == ST_RDATA_ACK && sda_s == ACK) begin
        load_tx = 1'b1;
        tx_idx  = ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      I2C_SDA_oe <= 1'b0;
      busy       <= 1'b0;
      stop_evt   <= 1'b0;
      nack_evt   <= 1'b0;
      ptr        <= '0;
      bit_cnt    <= '0;
      rw         <= 1'b0;
    end else begin
      stop_evt <= 1'b0;
      nack_evt <= 1'b0;
      if (evt == EVT_STOP) begin
        state      <= ST_IDLE;
        I2C_SDA_oe <= 1'b0;
        busy       <= 1'b0;
        stop_evt   <= 1'b1;
        bit_cnt    <= '0;
      end else if (evt == EVT_START) begin
        state      <= ST_ADDR;
        I2C_SDA_oe <= 1'b0;
        busy       <= 1'b1;
        bit_cnt    <= '0;
      end else if (scl_rise) begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              case (state)
                ST_ADDR: begin
                  if (addr_match(rx_byte, DEV_ADDR)) begin
                    state <= ST_ADDR_ACK;
                    rw    <= rx_byte[0];
                  end else begin
                    state <= ST_IGNORE;
                  end
                end
                ST_PTR: begin
                  ptr   <= rx_byte[AW-1:0];
                  state <= ST_PTR_ACK;
                end
                default: state <= ST_WDATA_ACK;
              endcase
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_ADDR_ACK:  state <= rw ? ST_RDATA : ST_PTR;
          ST_PTR_ACK:   state <= ST_WDATA;
          ST_WDATA_ACK: begin
            ptr   <= ptr + AW'(1);
            state <= ST_WDATA;
          end
          ST_RDATA: begin
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              state   <= ST_RDATA_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_RDATA_ACK: begin
            // The pointer moves past every byte put on the wire, ACKed or not.
            ptr <= ptr + AW'(1);
            if (sda_s == NACK) begin
              nack_evt <= 1'b1;
              state    <= ST_IGNORE;
            end else begin
              state <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: I2C_SDA_oe <= 1'b1;
          ST_RDATA:                              I2C_SDA_oe <= ~tx_sr[7];
          default:                               I2C_SDA_oe <= 1'b0;
        endcase
      end
    end
  end

  // Shift registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (scl_rise) begin
      rx_sr <= rx_byte[6:0];
    end
    if (load_tx) begin
      tx_sr <= regs[tx_idx];
    end else if (scl_rise && state == ST_RDATA) begin
      tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  // I2C write is ordered last so it wins a same-index collision with the host.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (host_wr_en) begin
        regs[host_addr] <= host_wdata;
      end
      if (i2c_we) begin
        regs[ptr] <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench: a bus master drives byte-level transactions; a transaction-level
// model of the register file predicts ACKs, read data and event counts.
module tb_i2c_target_responder;

  localparam int         SYNC_STAGES = 2;
  localparam int         REG_DEPTH   = 16;
  localparam logic [6:0] DEV_ADDR    = 7'h50;
  localparam int P_IDLE = 0, P_ADDR = 1, P_PTR = 2, P_DATA = 3, P_READ = 4, P_IGN = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic       host_wr_en = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic       busy;
  logic       stop_evt;
  logic       nack_evt;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] m_regs [REG_DEPTH];
  int m_ptr, m_phase, m_stop_cnt, m_nack_cnt;
  int stop_seen = 0;
  int nack_seen = 0;
  bit mon_en = 1'b0;
  bit oe_quiet = 1'b0;
  logic oe_prev = 1'b0;
  logic scl_prev = 1'b1;
  logic [7:0] rd_last;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_responder #(
    .DEV_ADDR(DEV_ADDR), .REG_DEPTH(REG_DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .I2C_SCL(scl_m), .I2C_SDA(sda_bus), .I2C_SDA_oe(sda_oe),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .busy(busy), .stop_evt(stop_evt), .nack_evt(nack_evt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  task automatic m_reset();
    for (int i = 0; i < REG_DEPTH; i++) m_regs[i] = 8'h00;
    m_ptr   = 0;
    m_phase = P_IDLE;
  endtask

  task automatic m_write(input logic [7:0] b, output logic exp_ack);
    exp_ack = 1'b0;
    case (m_phase)
      P_ADDR: begin
        if (b[7:1] == DEV_ADDR) m_phase = b[0] ? P_READ : P_PTR;
        else begin m_phase = P_IGN; exp_ack = 1'b1; end
      end
      P_PTR:  begin m_ptr = b % REG_DEPTH; m_phase = P_DATA; end
      P_DATA: begin m_regs[m_ptr] = b; m_ptr = (m_ptr + 1) % REG_DEPTH; end
      default: exp_ack = 1'b1;
    endcase
  endtask

  task automatic m_read(input logic ack, output logic [7:0] d);
    d = m_regs[m_ptr];
    m_ptr = (m_ptr + 1) % REG_DEPTH;
    if (ack) begin m_nack_cnt++; m_phase = P_IGN; end
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (stop_evt) stop_seen++;
    if (nack_evt) nack_seen++;
    if (mon_en) begin
      if (oe_quiet) chk("oe_released", sda_oe, 1'b0);
      if (scl_m && scl_prev) chk("oe_stable_scl_high", sda_oe, oe_prev);
    end
    oe_prev  = sda_oe;
    scl_prev = scl_m;
  end

  // ---------------- bus master ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b, input bit coll, output logic smp);
    sda_m = b;
    wait_clk(4);
    scl_m = 1'b1;
    if (coll) begin
      // host strobe lands on the same clk edge as the synchronized SCL rise
      wait_clk(SYNC_STAGES);
      host_wr_en = 1'b1;
      wait_clk(1);
      host_wr_en = 1'b0;
      wait_clk(4 - SYNC_STAGES - 1);
    end else begin
      wait_clk(4);
    end
    smp = sda_bus;
    wait_clk(4);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(6);
    sda_m = 1'b0;
    wait_clk(4);
    scl_m = 1'b0;
    wait_clk(4);
    if (m_phase == P_IDLE) m_ptr = m_ptr;
    m_phase = P_ADDR;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(4);
    scl_m = 1'b1;
    wait_clk(4);
    sda_m = 1'b1;
    wait_clk(8);
    m_phase = P_IDLE;
    m_stop_cnt++;
  endtask

  task automatic wr(input logic [7:0] b, input bit coll = 1'b0);
    logic exp_ack, ack, dmy;
    m_write(b, exp_ack);
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], coll && (i == 0), dmy);
    bit_cycle(1'b1, 1'b0, ack);
    chk($sformatf("ack_%02h", b), ack, exp_ack);
  endtask

  task automatic rd(input logic ack);
    logic [7:0] exp_d, d;
    logic dmy;
    m_read(ack, exp_d);
    for (int i = 7; i >= 0; i--) bit_cycle(1'b1, 1'b0, d[i]);
    bit_cycle(ack, 1'b0, dmy);
    rd_last = d;
    chk("read_byte", d, exp_d);
  endtask

  task automatic host_rd(input logic [3:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    host_addr = a;
    #1;
    chk(name, host_rdata, exp);
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host_addr  = a;
    host_wdata = d;
    host_wr_en = 1'b1;
    @(negedge clk);
    host_wr_en = 1'b0;
    m_regs[a]  = d;
  endtask

  task automatic check_regs();
    for (int i = 0; i < REG_DEPTH; i++) host_rd(4'(i), m_regs[i], $sformatf("regs_%0d", i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    m_stop_cnt = 0;
    m_nack_cnt = 0;
    wait_clk(4);
    chk("rst_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stop_evt", stop_evt, 1'b0);
    chk("rst_nack_evt", nack_evt, 1'b0);
    rst = 1'b0;
    wait_clk(2);
    mon_en = 1'b1;
    check_regs();

    // write burst from pointer 3
    i2c_start();
    chk("busy_after_start", busy, 1'b1);
    wr(8'hA0); wr(8'h03); wr(8'h5A); wr(8'hC3);
    i2c_stop();
    chk("busy_after_stop", busy, 1'b0);
    chk("stop_pulses_1", stop_seen, 1);
    host_rd(4'd3, 8'h5A, "lit_regs3");
    host_rd(4'd4, 8'hC3, "lit_regs4");
    check_regs();

    // repeated-START read: ACK then NACK
    i2c_start(); wr(8'hA0); wr(8'h03);
    i2c_start(); wr(8'hA1);
    rd(1'b0);
    chk("lit_read_5a", rd_last, 8'h5A);
    rd(1'b1);
    chk("lit_read_c3", rd_last, 8'hC3);
    i2c_stop();
    chk("nack_pulses_1", nack_seen, 1);
    host_wr(4'd5, 8'h6B);
    host_rd(4'd5, 8'h6B, "host_write_visible");
    i2c_start(); wr(8'hA1); rd(1'b1);
    chk("lit_ptr_is_5", rd_last, 8'h6B);
    i2c_stop();

    // address miss: never drives SDA, registers untouched
    i2c_start();
    oe_quiet = 1'b1;
    chk("miss_busy", busy, 1'b1);
    wr(8'hA2); wr(8'h03); wr(8'h99);
    i2c_stop();
    oe_quiet = 1'b0;
    chk("miss_busy_clear", busy, 1'b0);
    check_regs();

    // pointer wrap and pointer modulo
    i2c_start(); wr(8'hA0); wr(8'h0F); wr(8'h11); wr(8'h22); i2c_stop();
    host_rd(4'd15, 8'h11, "lit_wrap_regs15");
    host_rd(4'd0, 8'h22, "lit_wrap_regs0");
    i2c_start(); wr(8'hA0); wr(8'h13); i2c_start(); wr(8'hA1); rd(1'b1);
    chk("lit_ptr_mod", rd_last, 8'h5A);
    i2c_stop();

    // host and I2C write the same index on the same clock
    host_addr  = 4'd4;
    host_wdata = 8'hEE;
    m_regs[4]  = 8'hEE;
    i2c_start(); wr(8'hA0); wr(8'h04); wr(8'h77, 1'b1); i2c_stop();
    host_rd(4'd4, 8'h77, "lit_collision_i2c_wins");
    check_regs();
    chk("stop_pulses", stop_seen, m_stop_cnt);
    chk("nack_pulses", nack_seen, m_nack_cnt);

    // reset in the middle of a read while SDA is pulled low
    i2c_start(); wr(8'hA0); wr(8'h03); i2c_start(); wr(8'hA1);
    chk("lit_oe_driving_bit0", sda_oe, 1'b1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("oe_after_rst_edge", sda_oe, 1'b0);
    chk("busy_after_rst", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    wait_clk(4);
    mon_en = 1'b1;
    check_regs();
    i2c_start(); wr(8'hA1); rd(1'b1);
    chk("lit_after_rst_regs0", rd_last, 8'h00);
    i2c_stop();
    chk("stop_pulses_end", stop_seen, m_stop_cnt);
    chk("nack_pulses_end", nack_seen, m_nack_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
